// File: rtl/arm1_pkg.sv
// rtl/arm1_pkg.sv - shared state encoding and address defaults for the ARM1 address path
package arm1_pkg;

    localparam int ARM1_ADDR_W     = 26;
    localparam int ARM1_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2
    } arm1_state_e;

endpackage

// File: rtl/arm1_addr_incdec.sv
// rtl/arm1_addr_incdec.sv - combinational +/-STEP over ADDR_W bits with carry/borrow out
module arm1_addr_incdec #(
    parameter int ADDR_W = 26,
    parameter int STEP   = 4
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_dec,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_carry
);

    localparam logic [ADDR_W:0] STEP_EXT = (ADDR_W+1)'(STEP);

    logic [ADDR_W:0] w_sum;
    logic [ADDR_W:0] w_diff;

    // One extra bit catches carry out of the top (inc) or borrow below zero (dec)
    assign w_sum   = {1'b0, i_addr} + STEP_EXT;
    assign w_diff  = {1'b0, i_addr} - STEP_EXT;
    assign o_addr  = i_dec ? w_diff[ADDR_W-1:0] : w_sum[ADDR_W-1:0];
    assign o_carry = i_dec ? w_diff[ADDR_W] : w_sum[ADDR_W];

endmodule

// File: rtl/arm1_addr_sequencer.sv
// rtl/arm1_addr_sequencer.sv - ARM1 burst address sequencer; ADDR_EXC_EN enables the 26-bit address exception
module arm1_addr_sequencer
    import arm1_pkg::*;
#(
    parameter int ADDR_W    = ARM1_ADDR_W,
    parameter int INC_BYTES = ARM1_WORD_BYTES,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              burst_dir,
    input  logic              mem_wait,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              mreq,
    output logic              seq,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [CNT_W-1:0]  beat_idx,
    output logic              done,
    output logic              aborted,
    output logic              addr_exc
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BURST);

    arm1_state_e       r_state;
    arm1_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mreq;
    logic              r_seq;
    logic              r_dir;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_len;
    logic              r_done;
    logic              r_aborted;
    logic              r_exc;

    logic [CNT_W-1:0]  w_len_eff;
    logic [ADDR_W-1:0] w_step_addr;
    logic              w_step_carry;
    logic              w_pc_carry;
    logic              w_accept;
    logic              w_beat_ok;
    logic              w_final;
    logic              w_exc_fault;
    logic              w_unused;

    arm1_addr_incdec #(.ADDR_W(ADDR_W), .STEP(INC_BYTES)) u_step (
        .i_addr  (r_addr),
        .i_dec   (r_dir),
        .o_addr  (w_step_addr),
        .o_carry (w_step_carry)
    );

    arm1_addr_incdec #(.ADDR_W(ADDR_W), .STEP(INC_BYTES)) u_pc_inc (
        .i_addr  (r_addr),
        .i_dec   (1'b0),
        .o_addr  (pc_inc),
        .o_carry (w_pc_carry)
    );

    // PC-bus carry is meaningless; the step carry only matters with the exception enabled
    assign w_unused = w_pc_carry ^ w_step_carry;

    always_comb begin
        w_len_eff = burst_len;
        if (burst_len == '0) begin
            w_len_eff = CNT_W'(1);
        end else if (burst_len > MAX_LEN) begin
            w_len_eff = MAX_LEN;
        end
    end

    assign load_ready = rst && (r_state == IDLE);
    assign w_accept   = load_valid && load_ready;
    assign w_beat_ok  = (r_state == ACTIVE) && !mem_wait && !abort;
    assign w_final    = (r_idx == r_len - CNT_W'(1));

`ifdef ADDR_EXC_EN
    assign w_exc_fault = w_step_carry;
`else
    assign w_exc_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    w_state_nxt = FAULT;
                end else if (w_beat_ok) begin
                    if (w_final) begin
                        w_state_nxt = IDLE;
                    end else if (w_exc_fault) begin
                        w_state_nxt = FAULT;
                    end
                end
            end
            FAULT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_mreq    <= 1'b0;
            r_seq     <= 1'b0;
            r_dir     <= 1'b0;
            r_idx     <= '0;
            r_len     <= CNT_W'(1);
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_exc     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_exc     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= load_addr;
                        r_mreq <= 1'b1;
                        r_seq  <= 1'b0;
                        r_dir  <= burst_dir;
                        r_idx  <= '0;
                        r_len  <= w_len_eff;
                    end
                end
                ACTIVE: begin
                    // Abort wins over both wait and completion; the beat is not counted
                    if (abort) begin
                        r_mreq    <= 1'b0;
                        r_seq     <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (!mem_wait) begin
                        if (w_final) begin
                            r_mreq <= 1'b0;
                            r_seq  <= 1'b0;
                            r_done <= 1'b1;
                        end else if (w_exc_fault) begin
                            r_mreq <= 1'b0;
                            r_seq  <= 1'b0;
                            r_exc  <= 1'b1;
                        end else begin
                            r_addr <= w_step_addr;
                            r_seq  <= 1'b1;
                            r_idx  <= r_idx + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign addr     = r_addr;
    assign mreq     = r_mreq;
    assign seq      = r_seq;
    assign beat_idx = r_idx;
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign addr_exc = r_exc;

endmodule

// File: tb/tb_arm1_addr_sequencer.sv
// tb/tb_arm1_addr_sequencer.sv - self-checking bench for arm1_addr_sequencer (model + directed vectors)
module tb_arm1_addr_sequencer;

`ifdef ADDR_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [25:0] load_addr = '0;
    logic [4:0]  burst_len = '0;
    logic        burst_dir = 1'b0;
    logic        mem_wait = 1'b0;
    logic        abort = 1'b0;
    logic [25:0] addr;
    logic        mreq;
    logic        seq;
    logic [25:0] pc_inc;
    logic [4:0]  beat_idx;
    logic        done;
    logic        aborted;
    logic        addr_exc;

    int n_tests = 0;
    int n_fail  = 0;

    arm1_addr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .burst_len  (burst_len),
        .burst_dir  (burst_dir),
        .mem_wait   (mem_wait),
        .abort      (abort),
        .addr       (addr),
        .mreq       (mreq),
        .seq        (seq),
        .pc_inc     (pc_inc),
        .beat_idx   (beat_idx),
        .done       (done),
        .aborted    (aborted),
        .addr_exc   (addr_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: beat k of a burst sits at start +/- 4*k (mod 2^26)
    function automatic logic [25:0] beat_addr(input logic [25:0] s, input bit d, input int k);
        int unsigned off;
        off = 32'(k) * 4;
        return d ? 26'(32'(s) - off) : 26'(32'(s) + off);
    endfunction

    function automatic int eff_len(input logic [4:0] bl);
        if (bl == 0) return 1;
        if (bl > 16) return 16;
        return int'(bl);
    endfunction

    bit          m_active, m_fault, m_dir, m_done, m_abt, m_exc;
    logic [25:0] m_start;
    int          m_k, m_len;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 0; m_fault <= 0; m_dir <= 0; m_start <= '0;
            m_k <= 0; m_len <= 1; m_done <= 0; m_abt <= 0; m_exc <= 0;
        end else begin
            logic [25:0] cur;
            bit          crosses;
            cur     = beat_addr(m_start, m_dir, m_k);
            crosses = m_dir ? (cur < 26'd4) : ((33'(cur) + 33'd4) > 33'h3FFFFFF);
            m_done <= 0; m_abt <= 0; m_exc <= 0; m_fault <= 0;
            if (!m_active && !m_fault) begin
                if (load_valid) begin
                    m_active <= 1; m_start <= load_addr; m_dir <= burst_dir;
                    m_k <= 0; m_len <= eff_len(burst_len);
                end
            end else if (m_active) begin
                if (abort) begin
                    m_active <= 0; m_fault <= 1; m_abt <= 1;
                end else if (!mem_wait) begin
                    if (m_k == m_len - 1) begin
                        m_active <= 0; m_done <= 1;
                    end else if (EXC_EN && crosses) begin
                        m_active <= 0; m_fault <= 1; m_exc <= 1;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            logic [25:0] ea;
            ea = beat_addr(m_start, m_dir, m_k);
            chk("m_mreq", 32'(mreq), 32'(m_active));
            chk("m_addr", 32'(addr), 32'(ea));
            chk("m_pc_inc", 32'(pc_inc), 32'(26'(ea + 26'd4)));
            chk("m_seq", 32'(seq), 32'(m_active && m_k > 0));
            chk("m_load_ready", 32'(load_ready), 32'(!m_active && !m_fault));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_aborted", 32'(aborted), 32'(m_abt));
            chk("m_addr_exc", 32'(addr_exc), 32'(m_exc));
            if (m_active) chk("m_beat_idx", 32'(beat_idx), 32'(m_k));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [25:0] a, input logic [4:0] l, input bit d);
        load_valid = 1'b1; load_addr = a; burst_len = l; burst_dir = d;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (2) tick();
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_mreq", 32'(mreq), 32'h0);
        chk("rst_load_ready", 32'(load_ready), 32'h0);
        chk("rst_pulses", 32'({done, aborted, addr_exc, seq}), 32'h0);
        rst = 1'b1;
        tick();

        // inc burst of 4, no waits
        start(26'h100, 5'd4, 1'b0);
        chk("t1_a0", 32'(addr), 32'h100); chk("t1_seq0", 32'(seq), 32'h0);
        tick(); chk("t1_a1", 32'(addr), 32'h104); chk("t1_seq1", 32'(seq), 32'h1);
        tick(); chk("t1_a2", 32'(addr), 32'h108); chk("t1_i2", 32'(beat_idx), 32'h2);
        tick(); chk("t1_a3", 32'(addr), 32'h10C); chk("t1_i3", 32'(beat_idx), 32'h3);
        tick(); chk("t1_done", 32'(done), 32'h1); chk("t1_mreq", 32'(mreq), 32'h0);
        tick();

        // dec burst of 3 with two wait cycles on beat 1; load_valid ignored while busy
        start(26'h200, 5'd3, 1'b1);
        chk("t2_a0", 32'(addr), 32'h200);
        tick(); chk("t2_a1", 32'(addr), 32'h1FC);
        mem_wait = 1'b1; load_valid = 1'b1; load_addr = 26'hABC;
        tick(); chk("t2_w1", 32'(addr), 32'h1FC); chk("t2_w1i", 32'(beat_idx), 32'h1);
        tick(); chk("t2_w2", 32'(addr), 32'h1FC);
        mem_wait = 1'b0; load_valid = 1'b0;
        tick(); chk("t2_a2", 32'(addr), 32'h1F8);
        tick(); chk("t2_done", 32'(done), 32'h1);
        tick();

        // abort on beat 2
        start(26'h100, 5'd4, 1'b0);
        tick(); tick(); chk("t3_a2", 32'(addr), 32'h108);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("t3_mreq", 32'(mreq), 32'h0); chk("t3_aborted", 32'(aborted), 32'h1);
        chk("t3_addr", 32'(addr), 32'h108); chk("t3_lr_fault", 32'(load_ready), 32'h0);
        tick(); chk("t3_lr", 32'(load_ready), 32'h1); chk("t3_nodone", 32'(done), 32'h0);
        tick();

        // top-of-range step
        start(26'h3FFFFFC, 5'd2, 1'b0);
        chk("t4_a0", 32'(addr), 32'h3FFFFFC);
        tick();
        if (EXC_EN) begin
            chk("t4_exc", 32'(addr_exc), 32'h1); chk("t4_hold", 32'(addr), 32'h3FFFFFC);
            chk("t4_abt", 32'(aborted), 32'h0);
            tick(); chk("t4_nodone", 32'(done), 32'h0);
        end else begin
            chk("t4_wrap", 32'(addr), 32'h0); chk("t4_seq", 32'(seq), 32'h1);
            tick(); chk("t4_done", 32'(done), 32'h1);
        end
        tick();

        // reset during beat 1 of an 8-beat burst
        start(26'h300, 5'd8, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_addr", 32'(addr), 32'h0); chk("t5_mreq", 32'(mreq), 32'h0);
        chk("t5_seq", 32'(seq), 32'h0); chk("t5_lr", 32'(load_ready), 32'h0);
        tick();
        rst = 1'b1;
        tick(); chk("t5_nopulse", 32'({done, aborted, addr_exc}), 32'h0);
        start(26'h500, 5'd1, 1'b0);
        chk("t5_new", 32'(addr), 32'h500); chk("t5_newm", 32'(mreq), 32'h1);
        tick();

        // len 0 -> one beat, then back-to-back load in the done cycle
        start(26'h40, 5'd0, 1'b0);
        chk("t6_a0", 32'(addr), 32'h40);
        tick(); chk("t6_done", 32'(done), 32'h1); chk("t6_lr", 32'(load_ready), 32'h1);
        start(26'h80, 5'd2, 1'b0);
        chk("t6_b2b", 32'(addr), 32'h80); chk("t6_b2bm", 32'(mreq), 32'h1);
        chk("t6_b2bs", 32'(seq), 32'h0);
        tick(); tick(); tick();

        // over-long length saturates at 16 beats
        start(26'h0, 5'd31, 1'b0);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mreq) cnt++;
        end
        chk("t7_sat_beats", 32'(cnt), 32'd16);
        chk("t7_last", 32'(addr), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arm1_addr_sequencer.md
# arm1_addr_sequencer

Parametrised address register and sequencer for the ARM1 core, the successor of the bare address-register/PC-incrementer path. It latches a start address from the ALU bus and issues a burst of word transfers (1..MAX_BURST), incrementing or decrementing. It drives the address bus value, MREQ and SEQ, and honours memory wait, abort and an optional 26-bit address exception. It sits between the ALU result bus and the external address pads and serves instruction fetch and LDM/STM.

## Interface
Parameters:
- ADDR_W, 26, address width; all address arithmetic is modulo 2^ADDR_W.
- INC_BYTES, 4, step per beat in bytes.
- MAX_BURST, 16, maximum beats per burst.
- CNT_W, $clog2(MAX_BURST+1), width of the length and index fields.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  request to start a burst.
- load_ready  out  1  high in IDLE only; a load is accepted when load_valid && load_ready at a clk edge.
- load_addr  in  ADDR_W  start address, taken from the ALU bus.
- burst_len  in  CNT_W  number of beats; 0 is treated as 1, and values above MAX_BURST saturate to MAX_BURST.
- burst_dir  in  1  0 = increment, 1 = decrement.
- mem_wait  in  1  memory stall; the current beat does not complete.
- abort  in  1  memory abort for the current beat.
- addr  out  ADDR_W  current transfer address (registered).
- mreq  out  1  memory request (registered).
- seq  out  1  1 when addr = previous addr ± INC_BYTES (registered).
- pc_inc  out  ADDR_W  addr + INC_BYTES (combinational), feeds the PC bus.
- beat_idx  out  CNT_W  index of the current beat, 0..len-1.
- done  out  1  one-cycle pulse after the final beat completes.
- aborted  out  1  one-cycle pulse in the FAULT cycle caused by abort.
- addr_exc  out  1  one-cycle pulse in the FAULT cycle caused by address carry or borrow.

## Operation
- States: IDLE, ACTIVE, FAULT.
- IDLE, load accepted → ACTIVE. On the next edge: addr=load_addr, mreq=1, seq=0, beat_idx=0; length is latched.
- ACTIVE: a beat completes in a cycle with mreq && !mem_wait && !abort.
  - Non-final beat completes → addr ±= INC_BYTES, seq=1, beat_idx+1.
  - Final beat (beat_idx = len-1) completes → IDLE, mreq=0, seq=0, done=1.
- mem_wait high → addr, seq and beat_idx hold.
- abort high in ACTIVE, regardless of mem_wait, has priority over completion. → FAULT: mreq=0, addr holds, aborted=1. The aborted beat is not counted.
- FAULT lasts exactly one cycle, then → IDLE. load_ready is low in FAULT.
- load_valid is ignored outside IDLE.

## Timing
- Reset values (asynchronous, immediate while rst=0): state=IDLE, addr=0, mreq=0, seq=0, beat_idx=0, done=0, aborted=0, addr_exc=0. load_ready=0 while rst=0.
- Latency: acceptance edge → first mreq on the following cycle. An N-beat burst with no waits gives N mreq cycles; done is high in the first IDLE cycle.
- Back-to-back: load_ready is high during the done cycle. A new burst accepted there produces mreq with no gap cycle beyond done. seq=0 on the new first beat.
- Reset mid-burst: the burst is dropped and no done or aborted pulse is produced.
- Wrap-around without the macro: 0x3FFFFFC + 4 → 0x0000000 with seq=1.

## Configuration
- ADDR_EXC_EN defined: when a non-final beat completes and the address step would carry out of (increment) or borrow below (decrement) ADDR_W bits, the block goes to FAULT instead of advancing. In that FAULT cycle addr_exc=1, aborted=0, and addr holds.
- ADDR_EXC_EN undefined: addresses wrap silently and addr_exc is tied to 0.

## Structure
- Shared package arm1_pkg holds:
  - the state enum (IDLE/ACTIVE/FAULT);
  - the defaults ARM1_ADDR_W=26 and ARM1_WORD_BYTES=4.
- One sub-module, arm1_addr_incdec: combinational ±INC_BYTES over ADDR_W with carry/borrow out. It is instantiated for the step; pc_inc uses a second instance in increment mode.

## Test plan
- Load 0x0000100, len 4, inc, no waits → addr 0x100/0x104/0x108/0x10C, seq 0/1/1/1, beat_idx 0..3, done in the 5th cycle.
- Load 0x0000200, len 3, dec; mem_wait high for 2 cycles on beat 1 → addr 0x200, then 0x1FC held for 3 cycles, then 0x1F8; beat_idx holds at 1; done after the third beat.
- Len 4 from 0x100, abort during beat 2 (addr 0x108) → next cycle mreq=0, aborted=1, no done; load_ready high one cycle later.
- Load 0x3FFFFFC, len 2, inc:
  - with ADDR_EXC_EN → addr_exc=1, addr stays 0x3FFFFFC, no done;
  - without ADDR_EXC_EN → second beat at 0x0000000 with seq=1, then done.
- rst low during beat 1 of an 8-beat burst → addr=0, mreq=0, seq=0, no pulses; a new load is accepted after rst returns high.
- burst_len=0 from 0x40 → single beat at 0x40. Second load 0x80 in the done cycle → mreq at 0x80 with seq=0 the next cycle.
